// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the wb_rom_arbiter slice.
// Optional watchdog feature is enabled with the WB_ARB_TIMEOUT_EN macro.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    // Bits needed to hold 0..max_out inclusive.
    function automatic int cnt_width(input int max_out);
        return (max_out < 1) ? 1 : $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/wb_arb_outstanding.sv
// Outstanding-request counter for the ROM arbiter, with full/empty flags.
// With WB_ARB_TIMEOUT_EN defined it also runs the missing-ACK watchdog.
module wb_arb_outstanding
    import wb_arb_pkg::*;
#(
    parameter int MAX_OUT = 2,
`ifdef WB_ARB_TIMEOUT_EN
    parameter int TIMEOUT = 15,
`endif
    parameter int CW = cnt_width(MAX_OUT)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic ack_i,
    output logic full_o,
    output logic empty_o,
    output logic timeout_o
);

    localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUT);

    logic [CW-1:0] count_q, count_d;
    logic          dec;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    // An ACK with nothing in flight is a stray and must not underflow.
    assign dec     = ack_i & ~empty_o;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int            WW      = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

    logic [WW-1:0] wd_q, wd_d;

    assign timeout_o = ~empty_o & ~ack_i & (wd_q == WD_LAST);

    always_comb begin
        wd_d = wd_q + 1'b1;
        if (ack_i || empty_o || timeout_o) begin
            wd_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        count_d = count_q;
        if (timeout_o) begin
            count_d = '0;
        end else if (inc_i && !dec) begin
            count_d = count_q + 1'b1;
        end else if (dec && !inc_i) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wb_rom_arbiter.sv
// Two-master round-robin Wishbone pipelined arbiter in front of the program ROM.
// Define WB_ARB_TIMEOUT_EN to enable the missing-ACK watchdog and m*_err.
module wb_rom_arbiter
    import wb_arb_pkg::*;
#(
    parameter int AW      = 12,
    parameter int DW      = 16,
    parameter int MAX_OUT = 2
`ifdef WB_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 15
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_cyc,
    input  logic          m0_stb,
    input  logic [AW-1:0] m0_adr,
    input  logic          m1_cyc,
    input  logic          m1_stb,
    input  logic [AW-1:0] m1_adr,
    output logic          m0_ack,
    output logic          m1_ack,
    output logic          m0_stall,
    output logic          m1_stall,
    output logic          m0_err,
    output logic          m1_err,
    output logic [DW-1:0] m_dat,
    output logic          s_cyc,
    output logic          s_stb,
    output logic [AW-1:0] s_adr,
    input  logic          s_ack,
    input  logic          s_stall,
    input  logic [DW-1:0] s_dat
);

    arb_state_t state_q, state_d;
    logic       last_q, last_d;
    logic       full, empty, timeout, accept;
    logic [1:0] owner_vec, ack_vec, err_vec;

    wb_arb_outstanding #(
        .MAX_OUT (MAX_OUT)
`ifdef WB_ARB_TIMEOUT_EN
        ,
        .TIMEOUT (TIMEOUT)
`endif
    ) u_outstanding (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_i     (accept),
        .ack_i     (s_ack),
        .full_o    (full),
        .empty_o   (empty),
        .timeout_o (timeout)
    );

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_adr    = m0_adr;
        m0_stall = 1'b1;
        m1_stall = 1'b1;
        case (state_q)
            IDLE: begin
                // On a tie the master that was not served last wins.
                if (m0_cyc && (!m1_cyc || last_q)) begin
                    state_d = GNT0;
                    last_d  = 1'b0;
                end else if (m1_cyc) begin
                    state_d = GNT1;
                    last_d  = 1'b1;
                end
            end
            GNT0: begin
                // s_cyc stays up after the owner leaves so the ROM pipeline drains.
                s_cyc    = m0_cyc | ~empty;
                s_stb    = m0_stb & ~full;
                s_adr    = m0_adr;
                m0_stall = s_stall | full;
                if (timeout || (!m0_cyc && empty)) begin
                    state_d = IDLE;
                end
            end
            GNT1: begin
                s_cyc    = m1_cyc | ~empty;
                s_stb    = m1_stb & ~full;
                s_adr    = m1_adr;
                m1_stall = s_stall | full;
                if (timeout || (!m1_cyc && empty)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign accept    = s_stb & ~s_stall;
    assign owner_vec = {state_q == GNT1, state_q == GNT0};

    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
        assign ack_vec[gi] = s_ack & owner_vec[gi] & ~empty;
`ifdef WB_ARB_TIMEOUT_EN
        assign err_vec[gi] = timeout & owner_vec[gi];
`else
        assign err_vec[gi] = 1'b0;
`endif
    end

    assign m0_ack = ack_vec[0];
    assign m1_ack = ack_vec[1];
    assign m0_err = err_vec[0];
    assign m1_err = err_vec[1];
    assign m_dat  = s_dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_wb_rom_arbiter.sv
// Self-checking bench for wb_rom_arbiter: vector table, directed corner cases,
// and a randomized run against a transaction-level reference model.
module tb_wb_rom_arbiter;

    localparam int AW      = 12;
    localparam int DW      = 16;
    localparam int MAX_OUT = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m0_cyc = 1'b0, m0_stb = 1'b0, m1_cyc = 1'b0, m1_stb = 1'b0;
    logic [AW-1:0] m0_adr = '0, m1_adr = '0;
    logic          m0_ack, m1_ack, m0_stall, m1_stall, m0_err, m1_err;
    logic [DW-1:0] m_dat;
    logic          s_cyc, s_stb;
    logic [AW-1:0] s_adr;
    logic          s_ack = 1'b0, s_stall = 1'b0;
    logic [DW-1:0] s_dat = '0;

    int n_pass   = 0;
    int n_checks = 0;

    wb_rom_arbiter #(.AW(AW), .DW(DW), .MAX_OUT(MAX_OUT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m0_cyc   (m0_cyc),
        .m0_stb   (m0_stb),
        .m0_adr   (m0_adr),
        .m1_cyc   (m1_cyc),
        .m1_stb   (m1_stb),
        .m1_adr   (m1_adr),
        .m0_ack   (m0_ack),
        .m1_ack   (m1_ack),
        .m0_stall (m0_stall),
        .m1_stall (m1_stall),
        .m0_err   (m0_err),
        .m1_err   (m1_err),
        .m_dat    (m_dat),
        .s_cyc    (s_cyc),
        .s_stb    (s_stb),
        .s_adr    (s_adr),
        .s_ack    (s_ack),
        .s_stall  (s_stall),
        .s_dat    (s_dat)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_time_limit: simulation did not finish, got running expected finished");
        $fatal(1, "time limit");
    end

    function automatic logic [15:0] rom(input logic [11:0] a);
        return {a[3:0], a} ^ 16'hA55A;
    endfunction

    // {m0_ack, m1_ack, m0_stall, m1_stall, s_cyc, s_stb}
    function automatic logic [5:0] outs();
        return {m0_ack, m1_ack, m0_stall, m1_stall, s_cyc, s_stb};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_stall}
    task automatic drive(input logic [5:0] v);
        {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_stall} = v;
    endtask

    typedef struct packed {
        logic [5:0] in;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[22];

    // Reference-model and environment state for the random phase
    typedef struct {
        int         mst;
        logic [11:0] adr;
    } sb_t;
    typedef struct {
        logic [11:0] adr;
        int          due;
    } sl_t;

    sb_t         sb[$];
    sl_t         sl[$];
    int          own, last, cnt;
    bit          m_act[2];
    int          m_left[2];
    int          m_out[2];
    logic [11:0] m_next[2];
    logic        cyc[2], stb[2];
    logic [11:0] adr[2];

    initial begin
        // Reset values, no clock edge needed
        #2;
        chk("reset_outs", outs(), 6'b001100);
        chk("reset_err", {m0_err, m1_err}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

        vecs[0]  = '{6'b000000, 6'b001100};
        vecs[1]  = '{6'b110000, 6'b001100};
        vecs[2]  = '{6'b110000, 6'b000111};
        vecs[3]  = '{6'b110010, 6'b100111};
        vecs[4]  = '{6'b110000, 6'b000111};
        vecs[5]  = '{6'b110000, 6'b001110};
        vecs[6]  = '{6'b100010, 6'b101110};
        vecs[7]  = '{6'b001110, 6'b100110};
        vecs[8]  = '{6'b001100, 6'b000100};
        vecs[9]  = '{6'b001100, 6'b001100};
        vecs[10] = '{6'b001101, 6'b001111};
        vecs[11] = '{6'b001100, 6'b001011};
        vecs[12] = '{6'b001010, 6'b011010};
        vecs[13] = '{6'b111010, 6'b001010};
        vecs[14] = '{6'b110000, 6'b001000};
        vecs[15] = '{6'b111100, 6'b001100};
        vecs[16] = '{6'b111100, 6'b000111};
        vecs[17] = '{6'b001100, 6'b000110};
        vecs[18] = '{6'b001110, 6'b100110};
        vecs[19] = '{6'b001100, 6'b000100};
        vecs[20] = '{6'b111100, 6'b001100};
        vecs[21] = '{6'b111100, 6'b001011};

        m0_adr = 12'h010;
        m1_adr = 12'h800;
        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].in);
            #1;
            $display("vec %0d: in=%b outs=%b", i, vecs[i].in, outs());
            chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
            chk($sformatf("vec%0d_err", i), {m0_err, m1_err}, 2'b00);
            @(negedge clk);
        end

        // Async reset while GNT1 holds one outstanding request
        drive(6'b000010);
        m1_cyc = 1'b1;
        #1;
        chk("pre_reset_m1_ack", m1_ack, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        $display("async reset: outs=%b", outs());
        chk("async_reset_outs", outs(), 6'b001100);
        chk("async_reset_err", {m0_err, m1_err}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        s_ack = 1'b0;
        #1;
        chk("post_reset_idle", outs(), 6'b001100);
        @(negedge clk);
        s_ack = 1'b1;
        #1;
        chk("post_reset_regrant", outs(), 6'b001010);
        @(negedge clk);
        drive(6'b000000);

        // Single master, three back-to-back reads, 1-cycle slave
        @(negedge clk);
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 12'h010;
        #1;
        chk("sm_idle_no_stb", {s_stb, m0_ack}, 2'b00);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            m0_stb = (k <= 3);
            m0_adr = 12'h010 + 12'(k - 1);
            s_ack  = (k >= 2);
            s_dat  = (k >= 2) ? rom(12'h010 + 12'(k - 2)) : 16'hDEAD;
            #1;
            $display("single k=%0d: s_stb=%b s_adr=%h m0_ack=%b m_dat=%h", k, s_stb, s_adr, m0_ack, m_dat);
            chk($sformatf("sm%0d_flags", k), {s_stb, m0_stall, m1_stall, m0_ack},
                {(k <= 3), 1'b0, 1'b1, (k >= 2)});
            if (k <= 3) chk($sformatf("sm%0d_adr", k), s_adr, 12'h010 + 12'(k - 1));
            if (k >= 2) chk($sformatf("sm%0d_dat", k), m_dat, rom(12'h010 + 12'(k - 2)));
        end
        @(negedge clk);
        drive(6'b000000);
        @(negedge clk);

`ifdef WB_ARB_TIMEOUT_EN
        // Slave never acknowledges: watchdog fires on the 15th cycle after accept
        m0_cyc = 1'b1; m0_stb = 1'b1;
        @(negedge clk);
        #1;
        chk("to_accept", s_stb, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            m0_stb = 1'b0;
            if (k == 16) m0_cyc = 1'b0;
            #1;
            $display("timeout k=%0d: m0_err=%b s_cyc=%b", k, m0_err, s_cyc);
            if (k <= 15) chk($sformatf("to_err%0d", k), {m0_err, m1_err}, {(k == 15), 1'b0});
            else chk("to_idle", {s_cyc, m0_stall}, 2'b01);
        end
        @(negedge clk);
`endif

        // Randomized run against the reference model
        rst_n = 1'b0;
        drive(6'b000000);
        @(negedge clk);
        rst_n = 1'b1;
        own = -1; last = 1; cnt = 0;
        for (int n = 0; n < 2; n++) begin
            m_act[n] = 0; m_left[n] = 0; m_out[n] = 0; m_next[n] = '0;
        end
        for (int t = 0; t < 2000; t++) begin
            logic e_scyc, e_sstb, acc, av;
            logic [1:0] e_st, e_ack;
            int cnt_now;
            @(negedge clk);
            for (int n = 0; n < 2; n++) begin
                if (!m_act[n] && m_out[n] == 0 && $urandom_range(0, 3) == 0) begin
                    m_act[n]  = 1;
                    m_left[n] = $urandom_range(1, 4);
                    m_next[n] = 12'($urandom);
                end else if (m_act[n] && m_left[n] == 0 &&
                             (m_out[n] == 0 || $urandom_range(0, 3) == 0)) begin
                    m_act[n] = 0;
                end
                cyc[n] = m_act[n];
                stb[n] = m_act[n] && (m_left[n] > 0);
                adr[n] = m_next[n];
            end
            m0_cyc = cyc[0]; m0_stb = stb[0]; m0_adr = adr[0];
            m1_cyc = cyc[1]; m1_stb = stb[1]; m1_adr = adr[1];
            s_stall = ($urandom_range(0, 3) == 0);
            if (sl.size() > 0 && sl[0].due <= t && $urandom_range(0, 4) != 0) begin
                s_ack = 1'b1;
                s_dat = rom(sl[0].adr);
            end else begin
                s_ack = (sl.size() == 0) && ($urandom_range(0, 7) == 0);
                s_dat = 16'($urandom);
            end
            #1;
            e_scyc = (own >= 0) && (cyc[own] || cnt > 0);
            e_sstb = (own >= 0) && stb[own] && (cnt < MAX_OUT);
            for (int n = 0; n < 2; n++) begin
                e_st[n]  = (own != n) || s_stall || (cnt == MAX_OUT);
                e_ack[n] = s_ack && (own == n) && (cnt > 0);
            end
            chk($sformatf("rnd%0d_outs", t), {outs(), m0_err, m1_err},
                {e_ack[0], e_ack[1], e_st[0], e_st[1], e_scyc, e_sstb, 2'b00});
            chk($sformatf("rnd%0d_mdat", t), m_dat, s_dat);
            if (own >= 0) chk($sformatf("rnd%0d_sadr", t), s_adr, adr[own]);

            acc = e_sstb && !s_stall;
            av  = s_ack && (cnt > 0);
            if (acc) begin
                sb.push_back('{own, adr[own]});
                sl.push_back('{adr[own], t + int'($urandom_range(1, 3))});
                m_left[own]--;
                m_next[own]++;
                m_out[own]++;
                $display("rnd %0d: accept m%0d adr=%h", t, own, adr[own]);
            end
            if (av) begin
                sb_t h;
                h = sb.pop_front();
                void'(sl.pop_front());
                m_out[h.mst]--;
                $display("rnd %0d: ack m%0d adr=%h dat=%h", t, h.mst, h.adr, m_dat);
                chk($sformatf("rnd%0d_ack_dest", t), {m0_ack, m1_ack}, (h.mst == 0) ? 2'b10 : 2'b01);
                chk($sformatf("rnd%0d_ack_data", t), m_dat, rom(h.adr));
            end
            cnt_now = cnt;
            cnt = cnt + int'(acc) - int'(av);
            if (own < 0) begin
                if (cyc[0] && cyc[1]) own = 1 - last;
                else if (cyc[0]) own = 0;
                else if (cyc[1]) own = 1;
                if (own >= 0) last = own;
            end else if (!cyc[own] && cnt_now == 0) begin
                own = -1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_rom_arbiter.md
Name: wb_rom_arbiter

Overview:
- Two-master to one-slave Wishbone arbiter using classic pipelined bus cycles.
- Shares the single-port 4Kx16 program ROM between J1 instruction fetch (master 0) and a loader/debug read port (master 1).
- Sits between both masters and the ROM slave.
- Round-robin grant, held for the whole CYC of the owner; tracks outstanding requests so ACKs route to the correct master.

Parameters:
- AW, 12, address width forwarded to slave
- DW, 16, data width
- MAX_OUT, 2, max accepted-but-unacknowledged requests per grant (>=1)
- TIMEOUT, 15, cycles without ACK before error (used only with WB_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- m0_cyc, m0_stb, m1_cyc, m1_stb  in  1  master cycle/strobe
- m0_adr, m1_adr  in  AW  master address
- m0_ack, m1_ack  out  1  per-master acknowledge
- m0_stall, m1_stall  out  1  per-master stall
- m0_err, m1_err  out  1  per-master error
- m_dat  out  DW  read data, broadcast to both masters
- s_cyc, s_stb  out  1  to slave
- s_adr  out  AW  to slave
- s_ack  in  1  slave acknowledge
- s_stall  in  1  slave stall
- s_dat  in  DW  slave read data

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - State IDLE, outstanding count 0, last-served = 1 (master 0 wins the first tie).
  - All m*_ack, m*_err, s_cyc and s_stb are 0.
  - m0_stall and m1_stall are 1.
- States:
  - IDLE: no owner. If any mN_cyc is high, go to GNT0 or GNT1 next cycle.
    - If both request, grant the master not equal to last-served; update last-served.
    - Arbitration costs exactly 1 cycle. No strobe reaches the slave from IDLE.
  - GNTn:
    - s_cyc = mn_cyc; s_adr = mn_adr (combinational).
    - s_stb = mn_stb & (count < MAX_OUT).
    - mn_stall = s_stall | (count == MAX_OUT). The non-owner's stall is 1.
  - GNTn -> IDLE when mn_cyc = 0 and count = 0. Other master may be granted from IDLE on the following cycle; no direct GNT0 <-> GNT1 hop.
- Outstanding counter (width $clog2(MAX_OUT+1)):
  - +1 on accept (s_stb & ~s_stall).
  - -1 on s_ack.
  - Unchanged when both occur in the same cycle.
  - Never wraps: accept is blocked at MAX_OUT.
  - s_ack with count 0 is ignored, not forwarded, and does not underflow.
- Response routing:
  - mn_ack = s_ack & (owner == n) & (count != 0), combinational.
  - m_dat = s_dat unconditionally.
- Owner drops mn_cyc with count > 0: stay in GNTn with s_cyc held high until count reaches 0, so the ROM pipeline drains. Late ACKs are still routed to n.
- Reset asserted mid-cycle: immediate return to reset values; in-flight requests are dropped.

Optional Feature:
- WB_ARB_TIMEOUT_EN defined:
  - Watchdog counter clears on every s_ack and whenever count = 0.
  - It increments while count > 0.
  - On reaching TIMEOUT: mn_err pulses 1 cycle to the owner, count is forced to 0, state returns to IDLE.
- Undefined: m0_err and m1_err are tied 0, with no watchdog logic.

Decomposition:
- Package wb_arb_pkg:
  - typedef enum logic [1:0] {IDLE, GNT0, GNT1} arb_state_t
  - Outstanding-count width function
- Sub-module wb_arb_outstanding: up/down counter with full/empty flags and the watchdog when enabled. Instantiated once.

Test Plan:
- Single master: m0 issues 3 back-to-back strobes to 0x010, 0x011, 0x012 with a 1-cycle-latency slave. Required: grant in cycle 1; strobes accepted at 1/cycle; m0_ack on 3 consecutive cycles; m_dat = ROM[0x010..0x012]; m1_stall = 1 throughout.
- Simultaneous request out of reset: m0 and m1 assert cyc in the same cycle. Required: GNT0 first. After m0 drops cyc, IDLE for 1 cycle, then GNT1. On the next tie, m1 loses (round-robin).
- MAX_OUT=2 with a slave holding ack low for 3 cycles: third m0 strobe sees m0_stall = 1 and s_stb = 0 until the first ack, then is accepted.
- Owner drops cyc with 2 outstanding: s_cyc stays 1, both acks go to m0 only, m1 is granted only after count = 0.
- Stray s_ack in IDLE: no m*_ack asserted, count stays 0.
- Async reset pulse in GNT1 with count = 1: all outputs return to reset values without a clock edge; after reset, m1 is regranted via IDLE.
- With WB_ARB_TIMEOUT_EN and TIMEOUT=15, slave never acks: m0_err pulses on the 15th cycle after accept, state returns to IDLE, count = 0.
